dma_clkgate_ctrl: RTL
=====================

DMA_CLKGATE_CTRL -- requirements
Module: dma_clkgate_ctrl

Interface
REQ-001 The module SHALL have parameter IDLE_CYCLES, default 16, giving the number of consecutive idle cycles before gating; legal range 1..255.
REQ-002 The module SHALL have parameter WAKE_CYCLES, default 2, giving the settle cycles between clock re-enable and wake_ack; legal range 1..15.
REQ-003 Port clk  input  1  system clock; the only clock in the block.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port req  input  1  new DMA activity request, level, from the channel arbiter.
REQ-006 Port busy  input  1  DMA datapath busy, level.
REQ-007 Port bus_wait  input  1  bus stall from the system bus interface.
REQ-008 Port force_on  input  1  software override; holds the clock running.
REQ-009 Port enable  output  1  clock enable to the downstream clock gater.
REQ-010 Port wait_r  output  1  registered bus_wait to the downstream clock gater.
REQ-011 Port wake_ack  output  1  one-cycle pulse: gated clock is stable and DMA may start.
REQ-012 Port gated  output  1  status: clock is currently gated off.

Function
REQ-013 The block SHALL use an FSM with states GATED, WAKE, ACTIVE and IDLE, plus one 8-bit counter shared by WAKE and IDLE.
REQ-014 The definition of activity SHALL be act = req | busy | force_on.
REQ-015 In GATED, if act=1 the FSM SHALL go to WAKE with the counter cleared; otherwise it SHALL stay in GATED.
REQ-016 In WAKE, the counter SHALL increment each cycle; when it equals WAKE_CYCLES-1, the FSM SHALL go to ACTIVE and wake_ack SHALL be 1 for exactly that one transition cycle.
REQ-017 WAKE SHALL NOT be aborted by act falling; it always completes to ACTIVE.
REQ-018 In ACTIVE, if act=0 the FSM SHALL go to IDLE with the counter cleared; otherwise it SHALL stay in ACTIVE.
REQ-019 In IDLE, if act=1 the FSM SHALL return to ACTIVE and clear the counter.
REQ-020 In IDLE with act=0, when the counter equals IDLE_CYCLES-1 the FSM SHALL go to GATED; otherwise the counter SHALL increment.
REQ-021 When act=1 in the same cycle as the IDLE terminal count, activity SHALL win: the FSM goes to ACTIVE and never enters GATED.
REQ-022 Every output SHALL be registered; enable=1 in WAKE, ACTIVE and IDLE, and enable=0 in GATED.
REQ-023 Latency from act rising in GATED to enable=1 SHALL be 1 cycle; latency to wake_ack SHALL be WAKE_CYCLES+1 cycles.
REQ-024 wait_r SHALL equal bus_wait delayed by one clk cycle in all states.
REQ-025 gated SHALL be 1 exactly when the state is GATED.
REQ-026 The counter SHALL never wrap; it saturates at its terminal value within each state.

Reset
REQ-027 Asserting rst SHALL asynchronously force the following values: state=GATED, counter=0, enable=0, wait_r=0, wake_ack=0, gated=1.
REQ-028 Asserting rst mid-WAKE or mid-IDLE SHALL discard the count; after release the FSM re-enters WAKE only on a new act.
REQ-029 Release of rst SHALL be synchronised outside this block; the block assumes a clean deassertion.

Structure
REQ-030 The FSM state encoding (2-bit) and the default values of IDLE_CYCLES and WAKE_CYCLES SHALL live in the shared DMA package dma_pkg.
REQ-031 The block SHALL be a single module with no sub-modules; the clock gater is instantiated by the parent, not inside this block.

Verification
REQ-032 The bench SHALL drive reset and then hold act=0 for 50 cycles; the required response is enable=0, gated=1, and wake_ack never pulses.
REQ-033 The bench SHALL pulse req for 1 cycle from GATED with WAKE_CYCLES=2; the required response is enable=1 at +1 cycle, wake_ack high only at +3 cycles, ACTIVE, then after 16 idle cycles enable=0 at +20 cycles.
REQ-034 The bench SHALL drop busy for 15 cycles and reassert it on the 16th (terminal) cycle with IDLE_CYCLES=16; the required response is that enable never falls and the state returns to ACTIVE.
REQ-035 The bench SHALL hold force_on=1 with req=busy=0 for 100 cycles after wake; the required response is that enable stays 1 and gated stays 0.
REQ-036 The bench SHALL toggle bus_wait in the pattern 1,0,1,1; the required response is that wait_r shows 1,0,1,1 shifted by exactly one cycle, in both GATED and ACTIVE.
REQ-037 The bench SHALL assert rst at WAKE counter=1; the required response is that enable=0 immediately (asynchronously), no wake_ack occurs, and a later req restarts the full WAKE sequence.

Source files
------------

// File: rtl/dma_pkg.sv
// dma_pkg: shared DMA constants, FSM state encoding and clock-gating defaults
package dma_pkg;
    localparam logic [1:0] ST_GATED  = 2'd0;
    localparam logic [1:0] ST_WAKE   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_IDLE   = 2'd3;
    localparam int IDLE_CYCLES_DEF = 16;
    localparam int WAKE_CYCLES_DEF = 2;
endpackage

// File: rtl/dma_clkgate_ctrl_if.sv
// dma_clkgate_ctrl_if: activity inputs and gating outputs of the DMA clock-gate controller
interface dma_clkgate_ctrl_if;
    logic req;
    logic busy;
    logic bus_wait;
    logic force_on;
    logic enable;
    logic wait_r;
    logic wake_ack;
    logic gated;
    modport master (output req, busy, bus_wait, force_on, input enable, wait_r, wake_ack, gated);
    modport slave (input req, busy, bus_wait, force_on, output enable, wait_r, wake_ack, gated);
endinterface

// File: rtl/dma_clkgate_ctrl.sv
// dma_clkgate_ctrl: gates the DMA clock after a run of idle cycles and re-enables it on activity,
// with a fixed settle period before wake_ack.
module dma_clkgate_ctrl
    import dma_pkg::*;
#(
    parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
    parameter int WAKE_CYCLES = WAKE_CYCLES_DEF
) (
    input logic clk,
    input logic rst,
    dma_clkgate_ctrl_if.slave bus
);
    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic enable_q, wait_r_q, wake_ack_q, wake_ack_d, gated_q;
    logic act, wake_done, idle_done;

    always_comb begin
        act = bus.req | bus.busy | bus.force_on;
        wake_done = cnt_q == 8'(WAKE_CYCLES - 1);
        idle_done = cnt_q == 8'(IDLE_CYCLES - 1);
        state_d = state_q;
        cnt_d = cnt_q;
        wake_ack_d = 1'b0;
        case (state_q)
            ST_GATED: begin
                if (act) begin
                    state_d = ST_WAKE;
                    cnt_d = 8'd0;
                end
            end
            // WAKE ignores act: once the clock restarts it always settles fully
            ST_WAKE: begin
                if (wake_done) begin
                    state_d = ST_ACTIVE;
                    wake_ack_d = 1'b1;
                end else cnt_d = cnt_q + 8'd1;
            end
            ST_ACTIVE: begin
                if (!act) begin
                    state_d = ST_IDLE;
                    cnt_d = 8'd0;
                end
            end
            // activity takes priority over the terminal idle count
            ST_IDLE: begin
                if (act) begin
                    state_d = ST_ACTIVE;
                    cnt_d = 8'd0;
                end else if (idle_done) state_d = ST_GATED;
                else cnt_d = cnt_q + 8'd1;
            end
            default: begin
                state_d = ST_GATED;
                cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_GATED;
            cnt_q <= 8'd0;
            enable_q <= 1'b0;
            wait_r_q <= 1'b0;
            wake_ack_q <= 1'b0;
            gated_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            enable_q <= state_d != ST_GATED;
            wait_r_q <= bus.bus_wait;
            wake_ack_q <= wake_ack_d;
            gated_q <= state_d == ST_GATED;
        end
    end

    assign bus.enable = enable_q;
    assign bus.wait_r = wait_r_q;
    assign bus.wake_ack = wake_ack_q;
    assign bus.gated = gated_q;
endmodule
